// File: rtl/debug_pkg.sv
// Shared definitions for the debug run/step controller: command opcodes,
// FSM state encoding and the default program terminator.
package debug_pkg;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_RUN   = 8'h02;
  localparam logic [7:0] OP_STEP  = 8'h03;
  localparam logic [7:0] OP_DUMP  = 8'h04;
  localparam logic [7:0] OP_CLEAR = 8'h05;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_DATA = 3'd1,
    ST_LOAD_DONE = 3'd2,
    ST_RUN       = 3'd3,
    ST_STEP      = 3'd4,
    ST_STOP      = 3'd5,
    ST_DUMP_REQ  = 3'd6,
    ST_DUMP_WAIT = 3'd7
  } state_e;

endpackage

// File: rtl/debug_run_ctrl_if.sv
// Signal bundle between the debug controller and its environment
// (UART RX words, CPU halt/stall/reset, dump engine, instruction memory).
interface debug_run_ctrl_if;

  logic        rx_valid;
  logic [31:0] rx_data;
  logic        halt_detected;
  logic        dump_done;
  logic        dump_start;
  logic        cpu_stall;
  logic        cpu_soft_rst;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        cmd_error;

  modport master (
    output rx_valid, rx_data, halt_detected, dump_done,
    input  dump_start, cpu_stall, cpu_soft_rst, imem_we, imem_addr,
           imem_wdata, busy, cmd_error
  );

  modport slave (
    input  rx_valid, rx_data, halt_detected, dump_done,
    output dump_start, cpu_stall, cpu_soft_rst, imem_we, imem_addr,
           imem_wdata, busy, cmd_error
  );

endinterface

// File: rtl/dbg_load_seq.sv
// Program-load sequencer: address/remaining counters and a registered
// instruction-memory write port; done pulses alongside the final write.
module dbg_load_seq
  import debug_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] count,
  input  logic        word_valid,
  input  logic [31:0] word,
  output logic        done,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata
);

  logic        active_q, active_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;

  always_comb begin
    active_d = active_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    if (start) begin
      active_d = 1'b1;
      rem_d    = count;
      addr_d   = '0;
    end else if (word_valid && active_q) begin
      we_d    = 1'b1;
      waddr_d = addr_q;
      wdata_d = word;
      addr_d  = addr_q + 32'd1;
      rem_d   = rem_q - 16'd1;
      // The terminator word itself is still written before the load closes.
      if (rem_q == 16'd1 || word == HALT_WORD || addr_q == IMEM_DEPTH - 1) begin
        done_d   = 1'b1;
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      rem_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      rem_q    <= rem_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
    end
  end

  assign done       = done_q;
  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: rtl/debug_run_ctrl.sv
// Command-driven run/step controller for the MIPS debug path.
//   state     | meaning
//   IDLE      | CPU stalled, decoding commands
//   LOAD_DATA | streaming program words into imem
//   LOAD_DONE | one-cycle CPU soft reset after a load
//   RUN       | CPU free-running until halt or timeout
//   STEP      | CPU released for exactly one clock
//   STOP      | CPU re-stalled, one settling cycle
//   DUMP_REQ  | dump_start pulse
//   DUMP_WAIT | waiting for dump engine completion
module debug_run_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH  = 256,
  parameter logic [31:0] HALT_WORD   = HALT_WORD_DEFAULT,
  parameter logic [31:0] RUN_TIMEOUT = 32'd1_000_000
) (
  input logic              clk,
  input logic              rst,
  debug_run_ctrl_if.slave  bus
);

  state_e      state_q, state_d;
  logic        halted_q, halted_d;
  logic [31:0] run_cnt_q, run_cnt_d;
  logic        cpu_stall_q, cpu_stall_d;
  logic        dump_start_q, dump_start_d;
  logic        cpu_soft_rst_q, cpu_soft_rst_d;
  logic        busy_q, busy_d;
  logic        cmd_error_q, cmd_error_d;

  logic        load_start;
  logic        load_done;
  logic        clear_rst;
  logic [7:0]  opcode;
  logic [15:0] arg;
  logic        unused_rx_bits;

  assign opcode         = bus.rx_data[31:24];
  assign arg            = bus.rx_data[15:0];
  assign unused_rx_bits = ^bus.rx_data[23:16];

  dbg_load_seq #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .HALT_WORD  (HALT_WORD)
  ) u_load_seq (
    .clk        (clk),
    .rst        (rst),
    .start      (load_start),
    .count      (arg),
    .word_valid (bus.rx_valid && state_q == ST_LOAD_DATA),
    .word       (bus.rx_data),
    .done       (load_done),
    .imem_we    (bus.imem_we),
    .imem_addr  (bus.imem_addr),
    .imem_wdata (bus.imem_wdata)
  );

  always_comb begin
    state_d     = state_q;
    halted_d    = halted_q;
    run_cnt_d   = run_cnt_q;
    cmd_error_d = 1'b0;
    load_start  = 1'b0;
    clear_rst   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          case (opcode)
            OP_LOAD: begin
              if (arg == 16'd0) begin
                cmd_error_d = 1'b1;
              end else begin
                load_start = 1'b1;
                state_d    = ST_LOAD_DATA;
              end
            end
            OP_RUN: begin
              if (halted_q) begin
                cmd_error_d = 1'b1;
              end else begin
                state_d   = ST_RUN;
                run_cnt_d = RUN_TIMEOUT;
              end
            end
            OP_STEP: begin
              if (halted_q) cmd_error_d = 1'b1;
              else          state_d     = ST_STEP;
            end
            OP_DUMP:  state_d = ST_DUMP_REQ;
            OP_CLEAR: begin
              clear_rst = 1'b1;
              halted_d  = 1'b0;
            end
            default:  cmd_error_d = 1'b1;
          endcase
        end
      end
      ST_LOAD_DATA: begin
        // A word arriving alongside the final write has nowhere to go.
        if (load_done) begin
          state_d     = ST_LOAD_DONE;
          cmd_error_d = bus.rx_valid;
        end
      end
      ST_LOAD_DONE: begin
        halted_d = 1'b0;
        state_d  = ST_IDLE;
      end
      ST_RUN: begin
        if (bus.halt_detected) begin
          halted_d = 1'b1;
          state_d  = ST_STOP;
        end else if (run_cnt_q <= 32'd1) begin
          state_d = ST_STOP;
        end else begin
          run_cnt_d = run_cnt_q - 32'd1;
        end
      end
      ST_STEP: begin
        if (bus.halt_detected) halted_d = 1'b1;
        state_d = ST_STOP;
      end
      ST_STOP:      state_d = ST_DUMP_REQ;
      ST_DUMP_REQ:  state_d = ST_DUMP_WAIT;
      ST_DUMP_WAIT: if (bus.dump_done) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    if (bus.rx_valid && state_q != ST_IDLE && state_q != ST_LOAD_DATA)
      cmd_error_d = 1'b1;

    cpu_stall_d    = !(state_d == ST_RUN || state_d == ST_STEP);
    busy_d         = (state_d != ST_IDLE);
    dump_start_d   = (state_d == ST_DUMP_REQ);
    cpu_soft_rst_d = (state_d == ST_LOAD_DONE) || clear_rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      halted_q       <= 1'b0;
      run_cnt_q      <= '0;
      cpu_stall_q    <= 1'b1;
      dump_start_q   <= 1'b0;
      cpu_soft_rst_q <= 1'b0;
      busy_q         <= 1'b0;
      cmd_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      halted_q       <= halted_d;
      run_cnt_q      <= run_cnt_d;
      cpu_stall_q    <= cpu_stall_d;
      dump_start_q   <= dump_start_d;
      cpu_soft_rst_q <= cpu_soft_rst_d;
      busy_q         <= busy_d;
      cmd_error_q    <= cmd_error_d;
    end
  end

  assign bus.cpu_stall    = cpu_stall_q;
  assign bus.dump_start   = dump_start_q;
  assign bus.cpu_soft_rst = cpu_soft_rst_q;
  assign bus.busy         = busy_q;
  assign bus.cmd_error    = cmd_error_q;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Directed bench for debug_run_ctrl: imem writes checked through an expected
// queue, control outputs checked inline after each command.
module tb_debug_run_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_run_ctrl_if dbg_if();

  debug_run_ctrl #(
    .IMEM_DEPTH  (256),
    .HALT_WORD   (32'h0000_0000),
    .RUN_TIMEOUT (32'd100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dbg_if)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  n_run0 = 0;
  int  n_dstart = 0;
  int  n_srst = 0;
  int  n_wr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dbg_if.cpu_stall === 1'b0)    n_run0++;
    if (dbg_if.dump_start === 1'b1)   n_dstart++;
    if (dbg_if.cpu_soft_rst === 1'b1) n_srst++;
    if (dbg_if.imem_we === 1'b1) begin
      wr_t e;
      n_wr++;
      chk("wr_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", dbg_if.imem_addr, e.addr);
        chk("wr_data", dbg_if.imem_wdata, e.data);
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    dbg_if.rx_valid = 1'b1;
    dbg_if.rx_data  = w;
    tick();
    dbg_if.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] a);
    wr_t e;
    e.addr = a;
    e.data = w;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
    send(w);
  endtask

  task automatic finish_dump();
    dbg_if.dump_done = 1'b1;
    tick();
    dbg_if.dump_done = 1'b0;
  endtask

  initial begin
    int base_run, base_ds, base_sr, base_wr, guard;
    dbg_if.rx_valid      = 1'b0;
    dbg_if.rx_data       = '0;
    dbg_if.halt_detected = 1'b0;
    dbg_if.dump_done     = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_outputs",
        32'({dbg_if.cpu_stall, dbg_if.busy, dbg_if.imem_we, dbg_if.dump_start,
             dbg_if.cmd_error, dbg_if.cpu_soft_rst}), 32'b100000);
    rst = 1'b0;
    tick();

    // LOAD 3 words
    base_sr = n_srst;
    send(32'h0100_0003);
    chk("load_busy", 32'(dbg_if.busy), 32'd1);
    send_word(32'h2001_0005, 32'd0);
    send_word(32'h2002_0007, 32'd1);
    send_word(32'h0022_1820, 32'd2);
    tick();
    chk("load_done_srst", 32'(dbg_if.cpu_soft_rst), 32'd1);
    tick();
    chk("load_idle_busy", 32'(dbg_if.busy), 32'd0);
    tick();
    chk("load_srst_count", 32'(n_srst - base_sr), 32'd1);
    chk("load_queue_empty", 32'(exp_q.size()), 32'd0);

    // LOAD 10 terminated early by the halt word
    base_sr = n_srst;
    base_wr = n_wr;
    send(32'h0100_000A);
    send_word(32'h1111_1111, 32'd0);
    send_word(32'h2222_2222, 32'd1);
    send_word(32'h0000_0000, 32'd2);
    repeat (3) tick();
    chk("term_busy", 32'(dbg_if.busy), 32'd0);
    chk("term_writes", 32'(n_wr - base_wr), 32'd3);
    chk("term_srst_count", 32'(n_srst - base_sr), 32'd1);

    // RUN, halt after 40 cycles
    base_run = n_run0;
    base_ds  = n_dstart;
    send(32'h0200_0000);
    chk("run_stall", 32'(dbg_if.cpu_stall), 32'd0);
    repeat (39) tick();
    dbg_if.halt_detected = 1'b1;
    tick();
    dbg_if.halt_detected = 1'b0;
    chk("run_stop_stall", 32'(dbg_if.cpu_stall), 32'd1);
    chk("run_cycles", 32'(n_run0 - base_run), 32'd40);
    tick();
    chk("run_dump_start", 32'(dbg_if.dump_start), 32'd1);
    tick();
    chk("run_dump_wait", 32'({dbg_if.busy, dbg_if.dump_start}), 32'b10);
    repeat (3) tick();
    finish_dump();
    chk("run_idle", 32'(dbg_if.busy), 32'd0);
    chk("run_dstart_count", 32'(n_dstart - base_ds), 32'd1);
    send(32'h0200_0000);
    chk("run_halted_err", 32'({dbg_if.cmd_error, dbg_if.busy}), 32'b10);
    tick();
    chk("err_one_cycle", 32'(dbg_if.cmd_error), 32'd0);

    // CLEAR then three single steps
    send(32'h0500_0000);
    chk("clear_srst", 32'(dbg_if.cpu_soft_rst), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      base_run = n_run0;
      base_ds  = n_dstart;
      send(32'h0300_0000);
      chk("step_stall", 32'(dbg_if.cpu_stall), 32'd0);
      tick();
      chk("step_stop", 32'(dbg_if.cpu_stall), 32'd1);
      tick();
      chk("step_dump_start", 32'(dbg_if.dump_start), 32'd1);
      tick();
      send(32'h0300_0000);
      chk("step_reject", 32'({dbg_if.cmd_error, dbg_if.busy, dbg_if.cpu_stall}), 32'b111);
      finish_dump();
      chk("step_idle", 32'(dbg_if.busy), 32'd0);
      chk("step_run_cycles", 32'(n_run0 - base_run), 32'd1);
      chk("step_dstart_count", 32'(n_dstart - base_ds), 32'd1);
    end

    // illegal opcode, zero-length load, word during DUMP_WAIT
    send(32'h7F00_0000);
    chk("bad_opcode", 32'({dbg_if.cmd_error, dbg_if.busy}), 32'b10);
    send(32'h0100_0000);
    chk("load_zero", 32'({dbg_if.cmd_error, dbg_if.busy}), 32'b10);
    send(32'h0400_0000);
    chk("dump_cmd_start", 32'(dbg_if.dump_start), 32'd1);
    tick();
    send(32'h1234_5678);
    chk("dump_wait_word", 32'({dbg_if.cmd_error, dbg_if.busy}), 32'b11);
    tick();
    chk("dump_wait_hold", 32'({dbg_if.cmd_error, dbg_if.busy}), 32'b01);
    finish_dump();
    chk("dump_idle", 32'(dbg_if.busy), 32'd0);

    // RUN timeout forces a dump without setting halted
    base_run = n_run0;
    send(32'h0200_0000);
    guard = 0;
    while (dbg_if.cpu_stall === 1'b0 && guard < 300) begin
      tick();
      guard++;
    end
    chk("timeout_stopped", 32'(dbg_if.cpu_stall), 32'd1);
    chk("timeout_cycles", 32'(n_run0 - base_run), 32'd100);
    repeat (3) tick();
    finish_dump();
    send(32'h0300_0000);
    chk("timeout_not_halted", 32'({dbg_if.cmd_error, dbg_if.cpu_stall}), 32'b00);
    repeat (3) tick();
    finish_dump();

    // reset mid-load, then a fresh load restarts at address 0
    send(32'h0100_0005);
    send_word(32'hAAAA_0001, 32'd0);
    send_word(32'hAAAA_0002, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_load",
        32'({dbg_if.imem_we, dbg_if.cpu_stall, dbg_if.busy}), 32'b010);
    send(32'h0100_0003);
    send_word(32'hBBBB_0000, 32'd0);
    send_word(32'hBBBB_0001, 32'd1);
    send_word(32'hBBBB_0002, 32'd2);
    repeat (3) tick();
    chk("reload_idle", 32'(dbg_if.busy), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/debug_run_ctrl.md
Name: debug_run_ctrl

Overview:
Command-driven run/step controller for the pipelined MIPS debug path.
- Consumes 32-bit words delivered by the UART receiver and decodes them as commands.
- Loads program words into instruction memory, then releases the CPU to run continuously or for a single clock.
- Hands off to the existing dump engine (PC/regfile/memory/latch transmitter) through a start/done handshake.
- Sits between the UART RX word interface and the CPU stall/reset inputs.

Parameters:
IMEM_DEPTH, 256, instruction memory size in words; load address wraps to an error beyond this.
HALT_WORD, 32'h0000_0000, program terminator / halt instruction.
RUN_TIMEOUT, 32'd1_000_000, maximum RUN cycles before a forced dump.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle pulse: rx_data holds a complete received word
rx_data  in  32  received word
halt_detected  in  1  level: halt instruction has reached WB
dump_done  in  1  one-cycle pulse from dump engine: full dump transmitted
dump_start  out  1  one-cycle pulse requesting a full dump
cpu_stall  out  1  1 = PC and pipeline frozen
cpu_soft_rst  out  1  one-cycle CPU reset pulse after a completed load
imem_we  out  1  instruction memory write strobe
imem_addr  out  32  instruction memory word address
imem_wdata  out  32  instruction memory write data
busy  out  1  1 in any state other than IDLE
cmd_error  out  1  one-cycle pulse on an illegal or rejected command

Behaviour:
Reset values: cpu_stall=1; all other outputs 0; state=IDLE; halted flag=0; load counter=0.
Command word: opcode = rx_data[31:24], arg = rx_data[15:0].
Opcodes: 8'h01 LOAD, 8'h02 RUN, 8'h03 STEP, 8'h04 DUMP, 8'h05 CLEAR. Any other opcode raises cmd_error.

States:
- IDLE
  - cpu_stall=1.
  - Transitions on rx_valid:
    - LOAD with arg=0 -> cmd_error, stay IDLE.
    - LOAD with arg>0 -> LOAD_DATA; remaining=arg; addr=0.
    - RUN -> RUN, unless halted=1, which gives cmd_error.
    - STEP -> STEP, unless halted=1, which gives cmd_error.
    - DUMP -> DUMP_REQ.
    - CLEAR -> cpu_soft_rst pulse next cycle; halted=0; stay IDLE.
- LOAD_DATA
  - Each rx_valid writes one word. Next cycle: imem_we=1, imem_addr=addr, imem_wdata=word. Write latency is 1 cycle.
  - Then addr+1, remaining-1.
  - Exit to LOAD_DONE after the write that satisfies any of:
    - remaining reaches 0,
    - word==HALT_WORD (the terminator itself is written),
    - addr==IMEM_DEPTH-1.
  - rx_valid with addr already at IMEM_DEPTH is impossible by construction.
- LOAD_DONE
  - cpu_soft_rst=1 for exactly one cycle; halted=0; -> IDLE.
- RUN
  - cpu_stall=0; cycle counter increments.
  - -> STOP on halt_detected (set halted=1) or when the counter reaches RUN_TIMEOUT.
  - rx_valid while in RUN: cmd_error, word discarded.
- STEP
  - cpu_stall=0 for exactly one clock, then -> STOP.
  - halt_detected in that same cycle sets halted=1.
- STOP
  - cpu_stall=1; -> DUMP_REQ next cycle.
- DUMP_REQ
  - dump_start=1 for one cycle; -> DUMP_WAIT.
- DUMP_WAIT
  - cpu_stall=1; wait for dump_done -> IDLE.
  - rx_valid while waiting: cmd_error, word discarded.

Boundary rules:
- halt_detected while cpu_stall=1 has no effect except in the STEP cycle.
- dump_done outside DUMP_WAIT is ignored.
- rst mid-LOAD: no further imem_we, counter cleared, partial program left in memory.
- rst mid-DUMP_WAIT: return to IDLE; the dump engine is reset by the same rst.
- RUN reached from the CPU's previous PC: no implicit soft reset.

Decomposition:
Shared package debug_pkg holds:
- opcode localparams (OP_LOAD..OP_CLEAR),
- the state encoding (3-bit),
- HALT_WORD default.

One sub-module, dbg_load_seq: address/remaining counters plus the registered imem write path, with start, word_valid, word and done ports. The FSM stays in the top.

Test Plan:
- LOAD arg=3 with words 0x20010005, 0x20020007, 0x00221820 -> imem_we at addr 0,1,2 with matching data, one cycle after each rx_valid; cpu_soft_rst pulses once; busy falls afterwards.
- LOAD arg=10 with third word 0x00000000 -> three writes (the last is 0x0), LOAD_DONE entered, the remaining 7 words are not expected.
- RUN, then halt_detected asserted 40 cycles later -> cpu_stall=0 for exactly 40 cycles; dump_start pulses 2 cycles after halt; after dump_done, IDLE with halted=1; a following RUN gives a cmd_error pulse.
- STEP x3 -> each gives exactly one cpu_stall=0 cycle followed by one dump_start; no second step is accepted before the matching dump_done.
- Opcode 0x7F in IDLE, and any word during DUMP_WAIT -> one-cycle cmd_error each; no state change.
- rst asserted for one cycle mid-LOAD after 2 of 5 words -> next cycle: imem_we=0, cpu_stall=1, busy=0; a following 3-word LOAD restarts at addr 0.
